// File: rtl/pueo_l2scal_pkg.sv
// Shared constants and FSM state type for the level-two scaler block.
package pueo_l2scal_pkg;

  localparam int NSCAL_DEFAULT    = 24;
  localparam int CNT_BITS_DEFAULT = 16;
  localparam int SEQ_BITS_DEFAULT = 8;

  localparam int ADDR_TRIG   = NSCAL_DEFAULT;
  localparam int ADDR_STATUS = 31;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } l2scal_state_e;

endpackage

// File: rtl/pueo_l2scal_counter.sv
// One live scaler counter plus its snapshot register.
// PUEO_L2SCAL_SATURATE_EN makes the live counter stick at all-ones instead of wrapping.
module pueo_l2scal_counter
  import pueo_l2scal_pkg::*;
#(
  parameter int CNT_BITS = CNT_BITS_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ce_i,
  input  logic                inc_i,
  input  logic                clear_i,
  input  logic                latch_i,
  output logic [CNT_BITS-1:0] snap_o
);

  logic [CNT_BITS-1:0] live_q;
  logic [CNT_BITS-1:0] live_nxt;

  always_comb begin
    live_nxt = live_q;
    if (ce_i && inc_i) begin
`ifdef PUEO_L2SCAL_SATURATE_EN
      if (live_q != '1) live_nxt = live_q + CNT_BITS'(1);
`else
      live_nxt = live_q + CNT_BITS'(1);
`endif
    end
  end

  // The snapshot takes live_nxt so the terminal-cycle pulse lands in the closing period.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      live_q <= '0;
      snap_o <= '0;
    end else begin
      if (latch_i) snap_o <= live_nxt;
      if (clear_i) live_q <= '0;
      else         live_q <= live_nxt;
    end
  end

endmodule

// File: rtl/pueo_leveltwo_scalers.sv
// L2 sector and trigger rate scalers gated over PERIOD ce cycles, with a tear-free snapshot readout.
// Optional PUEO_L2SCAL_SATURATE_EN selects saturating rather than wrapping live counters.
module pueo_leveltwo_scalers
  import pueo_l2scal_pkg::*;
#(
  parameter int NSCAL    = NSCAL_DEFAULT,
  parameter int CNT_BITS = CNT_BITS_DEFAULT,
  parameter int PERIOD   = 1000000,
  parameter int SEQ_BITS = SEQ_BITS_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ce_i,
  input  logic [NSCAL-1:0]    scal_i,
  input  logic                trig_i,
  input  logic                enable_i,
  input  logic [4:0]          addr_i,
  input  logic                rd_i,
  output logic [31:0]         dat_o,
  output logic                dat_valid_o,
  output logic                update_o,
  output logic [SEQ_BITS-1:0] seq_o
);

  localparam int PER_W = $clog2(PERIOD);

  l2scal_state_e       state_q, state_d;
  logic [PER_W-1:0]    per_q;
  logic                active, cnt_en, term, clr;
  logic [NSCAL:0]      inc;
  logic [CNT_BITS-1:0] snap [NSCAL+1];
  logic [31:0]         rd_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i)  state_d = COUNT;
      COUNT:   if (!enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Dropping enable_i in COUNT stops counting at once and wipes the partial period.
  assign active = (state_q == COUNT) && enable_i;
  assign cnt_en = active && ce_i;
  assign term   = cnt_en && (per_q == PER_W'(PERIOD - 1));
  assign clr    = term || !active;
  assign inc    = {trig_i, scal_i};

  for (genvar g = 0; g <= NSCAL; g++) begin : g_cnt
    pueo_l2scal_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .ce_i    (cnt_en),
      .inc_i   (inc[g]),
      .clear_i (clr),
      .latch_i (term),
      .snap_o  (snap[g])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      per_q    <= '0;
      seq_o    <= '0;
      update_o <= 1'b0;
    end else begin
      update_o <= term;
      if (clr)         per_q <= '0;
      else if (cnt_en) per_q <= per_q + PER_W'(1);
      if (term) seq_o <= seq_o + SEQ_BITS'(1);
    end
  end

  // Mux reads pre-edge registers, so a read coinciding with a snapshot sees the old bank.
  always_comb begin
    rd_data = '0;
    if (addr_i == 5'(ADDR_STATUS))
      rd_data = 32'({seq_o, 7'b0, state_q == COUNT, 16'b0});
    else if (int'(addr_i) <= NSCAL)
      rd_data = 32'(snap[addr_i]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_o       <= '0;
      dat_valid_o <= 1'b0;
    end else begin
      dat_valid_o <= rd_i;
      if (rd_i) dat_o <= rd_data;
    end
  end

endmodule
